// File: rtl/move_sequencer.sv
// Game-level move initiator for the 4x4 node array: key -> ready injection,
// completion tracking, change detection, random tile spawn, win/over flags.
module move_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [3:0]  WIN_EXP        = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_dir,
    input  logic [3:0]  line_done,
    input  logic [63:0] board_value,
    output logic [3:0]  ready_inj,
    output logic [15:0] preset_cell,
    output logic [3:0]  preset_value,
    output logic        busy,
    output logic        move_done,
    output logic        game_won,
    output logic        game_over,
    output logic        timeout_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_INIT_SPAWN,
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SETTLE,
        S_SPAWN_SCAN,
        S_SPAWN_WRITE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [63:0]   snap;
    logic [3:0]    dir_lane;
    logic [3:0]    done_mask;
    logic [TW-1:0] wait_cnt;
    logic [3:0]    idx;
    logic [3:0]    scan_cnt;
    logic [1:0]    spawn_cnt;
    logic          from_move;

    logic          lfsr_fb_c;
    logic [3:0]    key_lane_c;
    logic          done_all_c;
    logic          cur_empty_c;
    logic          any_empty_c;
    logic          any_win_c;
    logic          any_pair_c;

    function automatic logic [3:0] cell_at(input logic [63:0] b, input int unsigned k);
        return b[4*k +: 4];
    endfunction

    assign lfsr_fb_c   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign done_all_c  = &(done_mask | line_done);
    assign cur_empty_c = (cell_at(board_value, 32'(idx)) == 4'd0);

    // Nodes pull from the side opposite the move, so the lane is mirrored.
    always_comb begin
        key_lane_c = 4'b0000;
        case (key_dir)
            4'b0001: key_lane_c = 4'b0100;
            4'b0010: key_lane_c = 4'b0001;
            4'b0100: key_lane_c = 4'b0010;
            4'b1000: key_lane_c = 4'b1000;
            default: key_lane_c = 4'b0000;
        endcase
    end

    // Board evaluation: empties, winning tile, any equal orthogonal pair (no row wrap).
    always_comb begin
        any_empty_c = 1'b0;
        any_win_c   = 1'b0;
        any_pair_c  = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (cell_at(board_value, k) == 4'd0)    any_empty_c = 1'b1;
            if (cell_at(board_value, k) == WIN_EXP) any_win_c   = 1'b1;
        end
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                if (cell_at(board_value, r*4 + c) == cell_at(board_value, r*4 + c + 1))
                    any_pair_c = 1'b1;
            end
        end
        for (int unsigned k = 0; k < 12; k++) begin
            if (cell_at(board_value, k) == cell_at(board_value, k + 4)) any_pair_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_INIT_SPAWN;
            lfsr         <= LFSR_SEED;
            snap         <= '0;
            dir_lane     <= '0;
            done_mask    <= '0;
            wait_cnt     <= '0;
            idx          <= '0;
            scan_cnt     <= '0;
            spawn_cnt    <= '0;
            from_move    <= 1'b0;
            ready_inj    <= '0;
            preset_cell  <= '0;
            preset_value <= '0;
            busy         <= 1'b0;
            move_done    <= 1'b0;
            game_won     <= 1'b0;
            game_over    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr_fb_c};
            ready_inj    <= '0;
            preset_cell  <= '0;
            preset_value <= '0;
            move_done    <= 1'b0;
            busy         <= 1'b1;
            case (state)
                S_INIT_SPAWN: begin
                    if (spawn_cnt == 2'd2) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= S_SPAWN_SCAN;
                        idx       <= lfsr[3:0];
                        scan_cnt  <= '0;
                        from_move <= 1'b0;
                    end
                end
                S_IDLE: begin
                    busy <= 1'b0;
                    if (key_valid && (key_lane_c != 4'b0000)) begin
                        state    <= S_ARM;
                        snap     <= board_value;
                        dir_lane <= key_lane_c;
                        busy     <= 1'b1;
                    end
                end
                S_ARM: begin
                    ready_inj <= dir_lane;
                    done_mask <= '0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    done_mask <= done_mask | line_done;
                    if (done_all_c) begin
                        state <= S_SETTLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_SETTLE: begin
                    if (board_value != snap) begin
                        state     <= S_SPAWN_SCAN;
                        idx       <= lfsr[3:0];
                        scan_cnt  <= '0;
                        from_move <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_SPAWN_SCAN: begin
                    if (cur_empty_c) begin
                        state        <= S_SPAWN_WRITE;
                        preset_cell  <= 16'(1) << idx;
                        preset_value <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                    end else if (scan_cnt == 4'd15) begin
                        state <= S_CHECK;
                    end else begin
                        idx      <= idx + 4'd1;
                        scan_cnt <= scan_cnt + 4'd1;
                    end
                end
                S_SPAWN_WRITE: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (any_win_c) game_won <= 1'b1;
                    move_done <= from_move;
                    if (!any_empty_c && !any_pair_c) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                        busy      <= 1'b0;
                    end else if (!from_move) begin
                        spawn_cnt <= spawn_cnt + 2'd1;
                        state     <= S_INIT_SPAWN;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_OVER: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural board that applies preset strobes.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_dir = 4'd0;
    logic [3:0]  line_done = 4'd0;
    logic [63:0] board;
    logic        load = 1'b0;
    logic [63:0] load_val = 64'd0;

    logic [3:0]  ready_inj;
    logic [15:0] preset_cell;
    logic [3:0]  preset_value;
    logic        busy, move_done, game_won, game_over, timeout_err;

    int checks = 0;
    int failures = 0;

    int n_strobe = 0;
    int n_md = 0;
    int n_rdy = 0;
    int n_bad = 0;
    logic [15:0] log_cell [0:7];
    logic [3:0]  log_val  [0:7];
    logic [15:0] prev_pc = 16'd0;

    move_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_dir      (key_dir),
        .line_done    (line_done),
        .board_value  (board),
        .ready_inj    (ready_inj),
        .preset_cell  (preset_cell),
        .preset_value (preset_value),
        .busy         (busy),
        .move_done    (move_done),
        .game_won     (game_won),
        .game_over    (game_over),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Board model: bench load wins, otherwise node presets land on the clock edge.
    always @(posedge clk) begin
        if (load) begin
            board <= load_val;
        end else begin
            for (int k = 0; k < 16; k++)
                if (preset_cell[k]) board[4*k +: 4] <= preset_value;
        end
    end

    // Event monitor: counts strobes and pulses seen during each cycle.
    always @(posedge clk) begin
        if (preset_cell != 16'd0) begin
            if (n_strobe < 8) begin
                log_cell[n_strobe] <= preset_cell;
                log_val[n_strobe]  <= preset_value;
            end
            if (prev_pc != 16'd0 || $countones(preset_cell) != 1) n_bad <= n_bad + 1;
            n_strobe <= n_strobe + 1;
        end
        if (move_done) n_md <= n_md + 1;
        if (ready_inj != 4'd0) n_rdy <= n_rdy + 1;
        prev_pc <= preset_cell;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_dir   = d;
        @(negedge clk);
        key_valid = 1'b0;
        key_dir   = 4'd0;
    endtask

    task automatic load_board(input logic [63:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Grid response: new board contents and line completions for one cycle.
    task automatic respond(input logic [63:0] v, input logic [3:0] ld);
        load      = 1'b1;
        load_val  = v;
        line_done = ld;
        @(negedge clk);
        load      = 1'b0;
        line_done = 4'd0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk(tag, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic int nz(input logic [63:0] b);
        int n = 0;
        for (int k = 0; k < 16; k++) if (b[4*k +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({ready_inj, preset_cell, preset_value, busy, move_done,
                    game_won, game_over, timeout_err});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, m0, r0;
        logic [63:0] bb, ba;

        // Reset state
        load_board(64'd0);
        repeat (2) @(negedge clk);
        chk("reset_outs", outs_vec(), 64'd0);

        // Two initial spawns from seed ACE1: cell 1 then cell 14, both tile 2
        rst = 1'b1;
        @(negedge clk);
        chk("init_busy", 64'(busy), 64'd1);
        wait_idle(60, "init_idle");
        chk("init_strobes", 64'(n_strobe), 64'd2);
        chk("init_cell0", 64'(log_cell[0]), 64'h0002);
        chk("init_val0", 64'(log_val[0]), 64'd1);
        chk("init_cell1", 64'(log_cell[1]), 64'h4000);
        chk("init_val1", 64'(log_val[1]), 64'd1);
        chk("init_board", board, 64'h0100_0000_0000_0010);
        chk("init_no_md", 64'(n_md), 64'd0);

        // Left move that merges row 0 -> one spawn and move_done
        load_board(64'h11);
        s0 = n_strobe; m0 = n_md;
        press(4'b0100);
        chk("t2_arm_lat", 64'(ready_inj), 64'd0);
        @(negedge clk);
        chk("t2_ready", 64'(ready_inj), 64'h2);
        respond(64'h2, 4'hF);
        chk("t2_ready_1cyc", 64'(ready_inj), 64'd0);
        wait_idle(60, "t2_idle");
        chk("t2_strobe", 64'(n_strobe - s0), 64'd1);
        chk("t2_md", 64'(n_md - m0), 64'd1);
        chk("t2_cells", 64'(nz(board)), 64'd2);
        chk("t2_flags", 64'({game_won, game_over, timeout_err}), 64'd0);

        // Left move on a board already packed left -> nothing happens
        load_board(64'h21);
        s0 = n_strobe; m0 = n_md;
        press(4'b0100);
        @(negedge clk);
        chk("t3_ready", 64'(ready_inj), 64'h2);
        respond(64'h21, 4'hF);
        wait_idle(60, "t3_idle");
        chk("t3_no_strobe", 64'(n_strobe - s0), 64'd0);
        chk("t3_no_md", 64'(n_md - m0), 64'd0);
        chk("t3_board", board, 64'h21);

        // Right move with one line never finishing -> timeout after 64 WAIT cycles
        s0 = n_strobe; m0 = n_md;
        press(4'b1000);
        @(negedge clk);
        chk("t4_ready", 64'(ready_inj), 64'h8);
        line_done = 4'b0111;
        repeat (63) @(negedge clk);
        chk("t4_before", 64'(timeout_err), 64'd0);
        @(negedge clk);
        chk("t4_timeout", 64'(timeout_err), 64'd1);
        chk("t4_idle", 64'(busy), 64'd0);
        line_done = 4'd0;
        repeat (2) @(negedge clk);
        chk("t4_no_spawn", 64'({n_strobe - s0, n_md - m0}), 64'd0);

        // Multi-hot key is ignored
        r0 = n_rdy;
        press(4'b0011);
        repeat (3) @(negedge clk);
        chk("t6_multihot_busy", 64'(busy), 64'd0);
        chk("t6_multihot_rdy", 64'(n_rdy - r0), 64'd0);

        // Key during WAIT is dropped, not queued
        r0 = n_rdy;
        press(4'b0001);
        @(negedge clk);
        chk("t6_up_ready", 64'(ready_inj), 64'h4);
        press(4'b0010);
        respond(board, 4'hF);
        wait_idle(60, "t6_drop_idle");
        repeat (4) @(negedge clk);
        chk("t6_drop_rdy", 64'(n_rdy - r0), 64'd1);
        chk("t6_drop_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of WAIT
        press(4'b0001);
        repeat (4) @(negedge clk);
        chk("t6c_wait_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 chk("t6c_async", outs_vec(), 64'd0);
        load_board(64'd0);
        rst = 1'b1;
        @(negedge clk);
        wait_idle(60, "t6c_reinit");
        chk("t6c_timeout_clr", 64'(timeout_err), 64'd0);

        // Move fills the board with no equal neighbours and a 2048 tile
        bb = 64'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bb[4*(r*4+c) +: 4] = (((r + c) % 2) == 0) ? 4'd1 : 4'd2;
        bb[23:20] = 4'd11;
        ba = bb;
        ba[63:60] = 4'd0;
        load_board(ba);
        s0 = n_strobe; m0 = n_md;
        press(4'b0010);
        @(negedge clk);
        chk("t5_ready", 64'(ready_inj), 64'h1);
        respond(bb, 4'hF);
        wait_idle(80, "t5_idle");
        chk("t5_over", 64'(game_over), 64'd1);
        chk("t5_won", 64'(game_won), 64'd1);
        chk("t5_md", 64'(n_md - m0), 64'd1);
        chk("t5_no_strobe", 64'(n_strobe - s0), 64'd0);
        r0 = n_rdy;
        press(4'b0100);
        repeat (5) @(negedge clk);
        chk("t5_keys_ignored", 64'(n_rdy - r0), 64'd0);
        chk("t5_over_state", 64'({busy, game_over}), 64'b01);
        chk("strobe_shape", 64'(n_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
